// File: rtl/urv_dm_bridge.sv
// urv_dm_bridge
// Data-memory responder for the uRV core. Turns single-cycle load/store
// requests from the execute stage into pipelined Wishbone accesses.
// Loads return registered data with a done pulse. Stores can be posted
// (done when launched) or completed (done on ack). A one-entry pending
// slot holds a request that arrives while the bus is busy.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   dm_addr_i           byte address (bits [1:0] dropped on the bus)
//   dm_data_s_i         store data, lane-replicated
//   dm_data_select_i    byte enables
//   dm_load_i/_store_i  single-cycle request strobes (load wins if both)
//   dm_data_l_o         load data, valid with dm_load_done_o
//   dm_load_done_o      load complete pulse
//   dm_store_done_o     store posted/complete pulse
//   dm_error_o          bus error / timeout pulse
//   wb_*                pipelined Wishbone master
//
// State | meaning
// IDLE  | no bus cycle
// REQ   | cyc=1 stb=1, waiting for !wb_stall_i
// WAIT  | cyc=1 stb=0, waiting for ack/err
module urv_dm_bridge #(
  parameter int unsigned g_timeout       = 255,
  parameter bit          g_posted_stores = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  localparam int TW = (g_timeout > 255) ? $clog2(g_timeout + 1) : 8;
  localparam bit TMO_EN = (g_timeout != 0);
  // Counter value in the last cycle before the abort edge, so that cyc
  // drops exactly g_timeout cycles after stb rises.
  localparam logic [TW-1:0] TMO_LAST = TW'(g_timeout - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic          slot_v_q;
  logic [31:0]   slot_adr_q;
  logic [31:0]   slot_dat_q;
  logic [3:0]    slot_sel_q;
  logic          slot_we_q;
  logic          post_q;
  logic [TW-1:0] tmo_q;

  logic          req_in;
  logic          we_in;
  logic          bus_term;
  logic          tmo_hit;
  logic          term;
  logic          is_err;
  logic          launch;
  logic          launch_slot;
  logic          slot_wr;

  // The bus is word addressed; the byte offset is carried by the selects.
  logic          unused_adr_lsb;
  assign unused_adr_lsb = ^dm_addr_i[1:0];

  always_comb begin
    req_in   = dm_load_i | dm_store_i;
    we_in    = dm_store_i & ~dm_load_i;
    // Ack/err during a stalled strobe is not a termination.
    bus_term = ((state_q == S_WAIT) || (state_q == S_REQ && !wb_stall_i)) &&
               (wb_ack_i || wb_err_i);
    tmo_hit  = TMO_EN && (state_q != S_IDLE) && !bus_term && (tmo_q == TMO_LAST);
    term     = bus_term | tmo_hit;
    is_err   = tmo_hit | (bus_term & wb_err_i);
    launch_slot = term & slot_v_q;
    // A request arriving on the termination cycle with an empty slot is
    // launched directly rather than parked.
    launch   = ((state_q == S_IDLE) && req_in) || (term && (slot_v_q || req_in));
    // Park the incoming request unless it is being launched now; a full,
    // non-draining slot drops it (core contract forbids that case).
    slot_wr  = req_in && (state_q != S_IDLE) && (term ? slot_v_q : !slot_v_q);

    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_in) state_d = S_REQ;
      S_REQ: begin
        if (term)             state_d = launch ? S_REQ : S_IDLE;
        else if (!wb_stall_i) state_d = S_WAIT;
      end
      S_WAIT: if (term) state_d = launch ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      slot_v_q        <= 1'b0;
      slot_adr_q      <= '0;
      slot_dat_q      <= '0;
      slot_sel_q      <= '0;
      slot_we_q       <= 1'b0;
      post_q          <= 1'b0;
      tmo_q           <= '0;
      dm_data_l_o     <= '0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_error_o      <= 1'b0;
      wb_adr_o        <= '0;
      wb_dat_o        <= '0;
      wb_sel_o        <= '0;
      wb_we_o         <= 1'b0;
      wb_cyc_o        <= 1'b0;
      wb_stb_o        <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_cyc_o <= (state_d != S_IDLE);
      wb_stb_o <= (state_d == S_REQ);

      dm_load_done_o  <= 1'b0;
      dm_error_o      <= 1'b0;
      dm_store_done_o <= post_q;
      post_q          <= 1'b0;

      if (launch) begin
        if (launch_slot) begin
          wb_adr_o <= slot_adr_q;
          wb_dat_o <= slot_dat_q;
          wb_sel_o <= slot_sel_q;
          wb_we_o  <= slot_we_q;
          post_q   <= g_posted_stores && slot_we_q;
        end else begin
          wb_adr_o <= {dm_addr_i[31:2], 2'b00};
          wb_dat_o <= dm_data_s_i;
          wb_sel_o <= dm_data_select_i;
          wb_we_o  <= we_in;
          post_q   <= g_posted_stores && we_in;
        end
        tmo_q <= '0;
      end else if (term) begin
        tmo_q <= '0;
      end else if (state_q != S_IDLE) begin
        tmo_q <= tmo_q + 1'b1;
      end

      if (slot_wr) begin
        slot_v_q   <= 1'b1;
        slot_adr_q <= {dm_addr_i[31:2], 2'b00};
        slot_dat_q <= dm_data_s_i;
        slot_sel_q <= dm_data_select_i;
        slot_we_q  <= we_in;
      end else if (launch_slot) begin
        slot_v_q <= 1'b0;
      end

      if (term) begin
        if (!wb_we_o) begin
          dm_load_done_o <= 1'b1;
          dm_error_o     <= is_err;
          dm_data_l_o    <= is_err ? 32'h0 : wb_dat_i;
        end else begin
          // Posted stores already reported done; only the error remains.
          dm_error_o <= is_err;
          if (!g_posted_stores) dm_store_done_o <= 1'b1;
        end
      end
    end
  end

endmodule
